// File: rtl/ntr_response_tx_pkg.sv
// Shared constants and state encoding for the NTR cartridge-bus response path.
// Pure declarations: no logic, no latency.
// Also used by the command decoder so both halves agree on framing.
package ntr_response_tx_pkg;

   localparam int         NTR_CMD_BYTES    = 8;
   localparam logic [7:0] NTR_FILL_DEFAULT = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } ntr_state_t;

   // Counter width for a count of n items, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ntr_edge_det.sv
// Edge pulse of an already-synchronised input against its registered history.
// Latency: pulse is high in the first clk cycle where sig differs from history.
// No backpressure; RST_VAL seeds the history so reset does not fake an edge.
module ntr_edge_det #(
   parameter logic RST_VAL = 1'b0,
   parameter bit   RISING  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic pulse
);

   logic sig_q;

   // One-cycle history of the input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_q <= RST_VAL;
      else     sig_q <= sig;
   end

   assign pulse = RISING ? (sig & ~sig_q) : (~sig & sig_q);

endmodule

// File: rtl/ntr_response_tx.sv
// NTR response transmitter: counts command bytes, then feeds stream bytes to the host.
// Latency: a byte is loaded 1 clk after the ntr_clk rise that requests it.
// Backpressure: stream is only consumed on a load; a missing byte is replaced by FILL.
module ntr_response_tx
   import ntr_response_tx_pkg::*;
#(
   parameter int         RESP_LEN  = 512,
   parameter logic [7:0] FILL      = NTR_FILL_DEFAULT,
   parameter int         CMD_BYTES = NTR_CMD_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ntr_clk_s,
   input  logic        ntr_cs1_s,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  ntr_data_out,
   output logic        ntr_oe,
   output logic        busy,
   output logic        underrun,
   output logic [12:0] byte_count
);

   localparam int             CW         = cnt_width(CMD_BYTES);
   localparam logic [CW-1:0]  CMD_LAST   = CW'(CMD_BYTES - 1);
   localparam logic [12:0]    RESP_LEN_C = 13'(RESP_LEN);

   ntr_state_t    state;
   logic [CW-1:0] cmd_cnt;
   logic          rise;
   logic          more;
   logic          load_now;
   logic [7:0]    load_byte;
   logic [12:0]   bc_next;

   // History reset to 1 so an ntr_clk already high after reset is not a rise
   ntr_edge_det #(
      .RST_VAL (1'b1),
      .RISING  (1'b1)
   ) u_clk_edge (
      .clk   (clk),
      .rst   (rst),
      .sig   (ntr_clk_s),
      .pulse (rise)
   );

   assign bc_next   = byte_count + 13'd1;
   assign more      = (bc_next < RESP_LEN_C);
   assign load_byte = tx_valid ? tx_data : FILL;

   // A byte is loaded on the last command rise or on a data rise with bytes still owed;
   // cs1 high masks any rise in the same cycle
   always_comb begin
      load_now = 1'b0;
      if (!ntr_cs1_s && rise) begin
         case (state)
            ST_CMD:  load_now = (cmd_cnt == CMD_LAST);
            ST_DATA: load_now = more;
            default: load_now = 1'b0;
         endcase
      end
   end

   // Stream handshake: consumed only when a load actually takes a valid byte
   assign tx_ready = load_now & tx_valid;
   assign busy     = (state != ST_IDLE);

   // Transaction FSM with counters and the output byte register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cmd_cnt      <= '0;
         byte_count   <= '0;
         underrun     <= 1'b0;
         ntr_data_out <= FILL;
         ntr_oe       <= 1'b0;
      end else if (state != ST_IDLE && ntr_cs1_s) begin
         // Deselect or abort: release the bus, keep counters for inspection
         state        <= ST_IDLE;
         ntr_oe       <= 1'b0;
         ntr_data_out <= FILL;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!ntr_cs1_s) begin
                  state      <= ST_CMD;
                  cmd_cnt    <= '0;
                  byte_count <= '0;
                  underrun   <= 1'b0;
               end
            end
            ST_CMD: begin
               if (rise) begin
                  if (load_now) begin
                     state        <= ST_DATA;
                     ntr_oe       <= 1'b1;
                     ntr_data_out <= load_byte;
                     if (!tx_valid) underrun <= 1'b1;
                  end else begin
                     cmd_cnt <= cmd_cnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (rise) begin
                  byte_count <= bc_next;
                  if (load_now) begin
                     ntr_data_out <= load_byte;
                     if (!tx_valid) underrun <= 1'b1;
                  end else begin
                     state        <= ST_DONE;
                     ntr_data_out <= FILL;
                  end
               end
            end
            default: begin
               // DONE: keep driving FILL, ignore further rises
               ntr_oe       <= 1'b1;
               ntr_data_out <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ntr_response_tx.sv
// Self-checking bench for ntr_response_tx with RESP_LEN=4.
// Host behaviour and upstream stream are modelled at transaction level.
// Summary line reports comparisons made and failed.
module tb_ntr_response_tx;

   localparam int         RL    = 4;
   localparam logic [7:0] FILLB = 8'hFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ntr_clk_s = 1'b0;
   logic        ntr_cs1_s = 1'b1;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  ntr_data_out;
   logic        ntr_oe;
   logic        busy;
   logic        underrun;
   logic [12:0] byte_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] strm[$];
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int         rdy_cnt;
   bit         oe_seen;
   bit         allow_valid;
   int         exp_rdy;
   bit         exp_und;
   int         exp_bc;

   ntr_response_tx #(.RESP_LEN(RL), .FILL(FILLB), .CMD_BYTES(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .ntr_clk_s    (ntr_clk_s),
      .ntr_cs1_s    (ntr_cs1_s),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .ntr_data_out (ntr_data_out),
      .ntr_oe       (ntr_oe),
      .busy         (busy),
      .underrun     (underrun),
      .byte_count   (byte_count)
   );

   always #5 clk = ~clk;

   // One clk cycle: optionally sample the bus, drive inputs, observe the handshake
   task automatic step(input logic c, input logic cs, input bit samp);
      @(negedge clk);
      if (samp) got.push_back(ntr_data_out);
      if (ntr_oe) oe_seen = 1'b1;
      ntr_clk_s = c;
      ntr_cs1_s = cs;
      tx_valid  = allow_valid && (strm.size() > 0);
      tx_data   = (strm.size() > 0) ? strm[0] : 8'h5A;
      #1;
      if (tx_ready) begin
         rdy_cnt++;
         if (strm.size() > 0) void'(strm.pop_front());
      end
   endtask

   // One host ntr_clk period: 2 clk high, 3 clk low; host samples just before rising
   task automatic rise_pulse(input bit samp, input bit v);
      allow_valid = v;
      step(1'b1, 1'b0, samp);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   // pat[k] = stream offers a byte for load k (load 0 on the last command rise)
   task automatic run_txn(input int ncmd, input int ndata, input bit [15:0] pat);
      got.delete();
      rdy_cnt = 0;
      oe_seen = 1'b0;
      allow_valid = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < ncmd; i++) rise_pulse(1'b0, pat[0]);
      for (int j = 1; j <= ndata; j++) rise_pulse(1'b1, (j < 16) ? pat[j] : 1'b0);
   endtask

   task automatic end_txn();
      allow_valid = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
   endtask

   // Transaction-level expectation for a full command phase followed by ndata host reads
   function automatic void model(input int ndata, input bit [15:0] pat, input logic [7:0] src_in[$]);
      logic [7:0] src[$];
      logic [7:0] loaded[$];
      int loads;
      src = src_in;
      exp_q.delete();
      exp_rdy = 0;
      exp_und = 1'b0;
      loads = 1 + ((ndata < RL - 1) ? ndata : RL - 1);
      for (int k = 0; k < loads; k++) begin
         if (pat[k] && src.size() > 0) begin
            loaded.push_back(src.pop_front());
            exp_rdy++;
         end else begin
            loaded.push_back(FILLB);
            exp_und = 1'b1;
         end
      end
      for (int j = 1; j <= ndata; j++) exp_q.push_back((j <= RL) ? loaded[j-1] : FILLB);
      exp_bc = (ndata < RL) ? ndata : RL;
   endfunction

   task automatic test_reset();
      #2 rst = 1'b1;
      #2;
      n_tests++;
      if ({ntr_oe, tx_ready, busy, underrun} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags got=%b want=0000", {ntr_oe, tx_ready, busy, underrun});
      end
      n_tests++;
      if (ntr_data_out !== FILLB) begin
         n_fail++;
         $display("FAIL reset_data got=%h want=%h", ntr_data_out, FILLB);
      end
      n_tests++;
      if (byte_count !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_count got=%0d want=0", byte_count);
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_basic();
      logic [7:0] want[4];
      want = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      strm.delete();
      for (int i = 0; i < 4; i++) strm.push_back(8'hA0 + 8'(i));
      run_txn(8, 4, 16'hFFFF);
      n_tests++;
      if (got.size() != 4) begin
         n_fail++;
         $display("FAIL basic_nsamp got=%0d want=4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got[i] !== want[i]) begin
               n_fail++;
               $display("FAIL basic_byte%0d got=%h want=%h", i, got[i], want[i]);
            end
         end
      end
      n_tests++;
      if (rdy_cnt != 4 || byte_count !== 13'd4 || underrun !== 1'b0 || ntr_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_status rdy=%0d bc=%0d und=%b oe=%b want 4/4/0/1",
                  rdy_cnt, byte_count, underrun, ntr_oe);
      end
      end_txn();
      n_tests++;
      if (ntr_oe !== 1'b0 || busy !== 1'b0 || ntr_data_out !== FILLB) begin
         n_fail++;
         $display("FAIL basic_release oe=%b busy=%b data=%h want 0/0/ff", ntr_oe, busy, ntr_data_out);
      end
   endtask

   task automatic test_underrun();
      logic [7:0] want[4];
      want = '{8'hA0, 8'hFF, 8'hA1, 8'hA2};
      strm.delete();
      for (int i = 0; i < 4; i++) strm.push_back(8'hA0 + 8'(i));
      run_txn(8, 4, 16'hFFFD);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (i >= got.size() || got[i] !== want[i]) begin
            n_fail++;
            $display("FAIL underrun_byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, want[i]);
         end
      end
      n_tests++;
      if (rdy_cnt != 3 || underrun !== 1'b1 || byte_count !== 13'd4) begin
         n_fail++;
         $display("FAIL underrun_status rdy=%0d und=%b bc=%0d want 3/1/4", rdy_cnt, underrun, byte_count);
      end
      end_txn();
   endtask

   task automatic test_overrun();
      logic [7:0] want[6];
      want = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hFF, 8'hFF};
      strm.delete();
      for (int i = 0; i < 8; i++) strm.push_back(8'hA0 + 8'(i));
      run_txn(8, 6, 16'hFFFF);
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (i >= got.size() || got[i] !== want[i]) begin
            n_fail++;
            $display("FAIL overrun_byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, want[i]);
         end
      end
      n_tests++;
      if (rdy_cnt != 4 || byte_count !== 13'd4 || strm.size() != 4) begin
         n_fail++;
         $display("FAIL overrun_status rdy=%0d bc=%0d left=%0d want 4/4/4", rdy_cnt, byte_count, strm.size());
      end
      end_txn();
   endtask

   task automatic test_abort();
      int r0;
      logic [7:0] want[4];
      want = '{8'hA2, 8'hA3, 8'hB0, 8'hB1};
      strm.delete();
      for (int i = 0; i < 4; i++) strm.push_back(8'hA0 + 8'(i));
      run_txn(8, 2, 16'hFFFE);
      r0 = rdy_cnt;
      allow_valid = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      allow_valid = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (rdy_cnt != r0) begin
         n_fail++;
         $display("FAIL abort_ready got=%0d want=%0d", rdy_cnt, r0);
      end
      n_tests++;
      if (ntr_oe !== 1'b0 || busy !== 1'b0 || byte_count !== 13'd2 || underrun !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_state oe=%b busy=%b bc=%0d und=%b want 0/0/2/1",
                  ntr_oe, busy, byte_count, underrun);
      end
      step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (byte_count !== 13'd0 || underrun !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_clear bc=%0d und=%b busy=%b want 0/0/1", byte_count, underrun, busy);
      end
      strm.push_back(8'hB0);
      strm.push_back(8'hB1);
      run_txn(8, 4, 16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (i >= got.size() || got[i] !== want[i]) begin
            n_fail++;
            $display("FAIL abort_next_byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, want[i]);
         end
      end
      end_txn();
   endtask

   task automatic test_cmd_phase();
      strm.delete();
      for (int i = 0; i < 4; i++) strm.push_back(8'hC0 + 8'(i));
      run_txn(7, 0, 16'hFFFF);
      end_txn();
      n_tests++;
      if (oe_seen || rdy_cnt != 0) begin
         n_fail++;
         $display("FAIL cmd_short oe_seen=%b rdy=%0d want 0/0", oe_seen, rdy_cnt);
      end
      run_txn(7, 0, 16'hFFFF);
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (oe_seen || ntr_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL cmd_seven oe=%b want 0", ntr_oe);
      end
      rise_pulse(1'b0, 1'b1);
      n_tests++;
      if (ntr_oe !== 1'b1 || rdy_cnt != 1 || ntr_data_out !== 8'hC0) begin
         n_fail++;
         $display("FAIL cmd_eighth oe=%b rdy=%0d data=%h want 1/1/c0", ntr_oe, rdy_cnt, ntr_data_out);
      end
      end_txn();
   endtask

   task automatic test_reset_mid();
      strm.delete();
      for (int i = 0; i < 4; i++) strm.push_back(8'hD0 + 8'(i));
      run_txn(8, 2, 16'hFFFF);
      @(negedge clk);
      #2;
      ntr_clk_s = 1'b1;
      rst = 1'b1;
      #1;
      n_tests++;
      if (ntr_oe !== 1'b0 || ntr_data_out !== FILLB || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async oe=%b data=%h busy=%b want 0/ff/0", ntr_oe, ntr_data_out, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      got.delete();
      rdy_cnt = 0;
      oe_seen = 1'b0;
      allow_valid = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) rise_pulse(1'b0, 1'b1);
      n_tests++;
      if (oe_seen || rdy_cnt != 0) begin
         n_fail++;
         $display("FAIL rst_false_rise oe_seen=%b rdy=%0d want 0/0", oe_seen, rdy_cnt);
      end
      rise_pulse(1'b0, 1'b1);
      n_tests++;
      if (ntr_oe !== 1'b1 || rdy_cnt != 1) begin
         n_fail++;
         $display("FAIL rst_restart oe=%b rdy=%0d want 1/1", ntr_oe, rdy_cnt);
      end
      end_txn();
   endtask

   task automatic test_random();
      logic [7:0] snap[$];
      bit [15:0]  pat;
      int         nd;
      for (int it = 0; it < 10; it++) begin
         strm.delete();
         for (int i = 0; i < 2 + $urandom_range(0, 6); i++) strm.push_back(8'($urandom));
         pat = 16'($urandom);
         nd  = $urandom_range(0, 6);
         snap = strm;
         model(nd, pat, snap);
         run_txn(8, nd, pat);
         n_tests++;
         if (got != exp_q) begin
            n_fail++;
            $display("FAIL rand%0d_bytes got=%p want=%p", it, got, exp_q);
         end
         n_tests++;
         if (rdy_cnt != exp_rdy || underrun !== exp_und || byte_count !== 13'(exp_bc)) begin
            n_fail++;
            $display("FAIL rand%0d_status rdy=%0d und=%b bc=%0d want %0d/%b/%0d",
                     it, rdy_cnt, underrun, byte_count, exp_rdy, exp_und, exp_bc);
         end
         end_txn();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_overrun();
      test_abort();
      test_cmd_phase();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
